// File: rtl/booth_multiplier.sv
// booth_multiplier
//   Unsigned 16x16 -> 32-bit multiplier, fully pipelined at one product per cycle.
//   Datapath: radix-4 modified Booth recoding of y (zero-extended to 18 bits,
//   9 digits) -> 9 partial products plus one negation-correction vector ->
//   3:2 carry-save tree down to two 32-bit vectors -> 32-bit Kogge-Stone adder.
//
//   Compile-time option:
//     BOOTH_PIPE_EN  defined   : register between CSA tree and Kogge-Stone adder,
//                                latency 2 cycles.
//                    undefined : latency 1 cycle.
//   Ports are identical in both builds.
//
// Ports
//   clk        in   single clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset, clears all state
//   in_valid   in   x/y carry a new operand pair this cycle
//   x          in   [15:0] unsigned multiplicand
//   y          in   [15:0] unsigned multiplier
//   out_valid  out  sum carries a new product this cycle
//   sum        out  [31:0] unsigned product x*y (holds when out_valid=0)
//
// Handshake: in_valid/out_valid are valid-only qualifiers. There is no ready;
// the pipeline advances every cycle, so a pair accepted with in_valid=1 always
// emerges exactly LATENCY edges later with out_valid=1, in issue order, and a
// cycle with in_valid=0 produces a bubble (out_valid=0, sum unchanged).

module booth_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic        out_valid,
  output logic [31:0] sum
);

  // One Booth digit -> {neg, partial product}. Negative digits are returned as
  // the one's complement of the magnitude; the +1 is supplied separately by
  // the correction vector at bit sh. The complement is taken before the shift
  // so the low sh bits stay zero and the +1 lands exactly on weight 2^sh.
  function automatic logic [32:0] booth_pp(input logic [2:0]  d,
                                           input logic [15:0] m,
                                           input int          sh);
    logic [31:0] mag;
    logic        neg;
    mag = '0;
    neg = 1'b0;
    case (d)
      3'b001, 3'b010: mag = {16'b0, m};
      3'b011:         mag = {15'b0, m, 1'b0};
      3'b100: begin
        mag = {15'b0, m, 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = {16'b0, m};
        neg = 1'b1;
      end
      default: ;  // 000 and 111 are digit 0
    endcase
    if (neg) mag = ~mag;
    return {neg, mag << sh};
  endfunction

  // 3:2 compressor on 32-bit vectors -> {carry (pre-shifted), sum}.
  function automatic logic [63:0] csa(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [31:0] c);
    logic [31:0] s;
    logic [31:0] cy;
    s  = a ^ b ^ c;
    cy = (a & b) | (a & c) | (b & c);
    return {cy[30:0], 1'b0, s};
  endfunction

  // One Kogge-Stone prefix level at span d -> {g, p}.
  function automatic logic [63:0] ks_step(input logic [31:0] g,
                                          input logic [31:0] p,
                                          input int          d);
    logic [31:0] gn;
    logic [31:0] pn;
    for (int i = 0; i < 32; i++) begin
      if (i >= d) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end else begin
        gn[i] = g[i];
        pn[i] = p[i];
      end
    end
    return {gn, pn};
  endfunction

  // ---------------- input stage ----------------
  logic        r_in_v;
  logic [15:0] r_x;
  logic [15:0] r_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_v <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
    end else begin
      r_in_v <= in_valid;
      if (in_valid) begin
        r_x <= x;
        r_y <= y;
      end
    end
  end

  // ---------------- Booth recoding ----------------
  // Bit 0 is the implicit y[-1]=0; top two zeros make the 18-bit extension,
  // so digit 8 is only ever 0 or +1 and the multiplier stays unsigned.
  logic [18:0] w_y_ext;
  logic [31:0] w_pp  [9];
  logic        w_neg [9];
  logic [31:0] w_corr;

  assign w_y_ext = {2'b00, r_y, 1'b0};

  for (genvar gi = 0; gi < 9; gi++) begin : g_pp
    assign {w_neg[gi], w_pp[gi]} = booth_pp(w_y_ext[2*gi+2 -: 3], r_x, 2*gi);
  end

  always_comb begin
    w_corr = '0;
    for (int i = 0; i < 9; i++) begin
      w_corr[2*i] = w_neg[i];
    end
  end

  // ---------------- carry-save tree: 10 -> 7 -> 5 -> 4 -> 3 -> 2 ----------------
  logic [31:0] w_s1a, w_c1a, w_s1b, w_c1b, w_s1c, w_c1c;
  logic [31:0] w_s2a, w_c2a, w_s2b, w_c2b;
  logic [31:0] w_s3, w_c3;
  logic [31:0] w_s4, w_c4;
  logic [31:0] w_csa_s, w_csa_c;

  assign {w_c1a, w_s1a}     = csa(w_pp[0], w_pp[1], w_pp[2]);
  assign {w_c1b, w_s1b}     = csa(w_pp[3], w_pp[4], w_pp[5]);
  assign {w_c1c, w_s1c}     = csa(w_pp[6], w_pp[7], w_pp[8]);
  assign {w_c2a, w_s2a}     = csa(w_s1a, w_c1a, w_s1b);
  assign {w_c2b, w_s2b}     = csa(w_c1b, w_s1c, w_c1c);
  assign {w_c3, w_s3}       = csa(w_s2a, w_c2a, w_s2b);
  assign {w_c4, w_s4}       = csa(w_s3, w_c3, w_c2b);
  assign {w_csa_c, w_csa_s} = csa(w_s4, w_c4, w_corr);

  // ---------------- optional CSA / adder register ----------------
  logic [31:0] w_ks_a;
  logic [31:0] w_ks_b;
  logic        w_ks_v;

`ifdef BOOTH_PIPE_EN
  logic [31:0] r_pipe_s;
  logic [31:0] r_pipe_c;
  logic        r_pipe_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_v <= 1'b0;
      r_pipe_s <= '0;
      r_pipe_c <= '0;
    end else begin
      r_pipe_v <= r_in_v;
      if (r_in_v) begin
        r_pipe_s <= w_csa_s;
        r_pipe_c <= w_csa_c;
      end
    end
  end

  assign w_ks_a = r_pipe_s;
  assign w_ks_b = r_pipe_c;
  assign w_ks_v = r_pipe_v;
`else
  assign w_ks_a = w_csa_s;
  assign w_ks_b = w_csa_c;
  assign w_ks_v = r_in_v;
`endif

  // ---------------- Kogge-Stone final adder ----------------
  // The true product always fits in 32 bits, and the sign-extended partial
  // products wrap modulo 2^32, so the carry-out is meaningless and dropped.
  logic [31:0] w_ks_g0, w_ks_p0;
  logic [31:0] w_ks_g1, w_ks_p1;
  logic [31:0] w_ks_g2, w_ks_p2;
  logic [31:0] w_ks_g3, w_ks_p3;
  logic [31:0] w_ks_g4, w_ks_p4;
  logic [31:0] w_ks_g5, w_ks_p5;
  logic [31:0] w_ks_sum;
  logic [32:0] w_unused_ks;

  assign w_ks_g0 = w_ks_a & w_ks_b;
  assign w_ks_p0 = w_ks_a ^ w_ks_b;
  assign {w_ks_g1, w_ks_p1} = ks_step(w_ks_g0, w_ks_p0, 1);
  assign {w_ks_g2, w_ks_p2} = ks_step(w_ks_g1, w_ks_p1, 2);
  assign {w_ks_g3, w_ks_p3} = ks_step(w_ks_g2, w_ks_p2, 4);
  assign {w_ks_g4, w_ks_p4} = ks_step(w_ks_g3, w_ks_p3, 8);
  assign {w_ks_g5, w_ks_p5} = ks_step(w_ks_g4, w_ks_p4, 16);
  assign w_ks_sum    = w_ks_p0 ^ {w_ks_g5[30:0], 1'b0};
  assign w_unused_ks = {w_ks_g5[31], w_ks_p5};

  // ---------------- output stage ----------------
  logic        r_out_v;
  logic [31:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v <= 1'b0;
      r_sum   <= '0;
    end else begin
      r_out_v <= w_ks_v;
      if (w_ks_v) r_sum <= w_ks_sum;
    end
  end

  assign out_valid = r_out_v;
  assign sum       = r_sum;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier
//   Directed bench for booth_multiplier: corner-product table, 66x66 sweep
//   against x*y, streaming, bubble, mid-operation reset. Latency follows the
//   BOOTH_PIPE_EN build option (2 when defined, 1 otherwise).

module tb_booth_multiplier;

`ifdef BOOTH_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic [31:0] sum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  booth_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .sum       (sum)
  );

  // ---------------- scoreboard ----------------
  int          checks;
  int          failures;
  int          num_correct;
  int          num_wrong;
  logic [31:0] model_sum;
  logic [32:0] exp_q[$];   // {valid, sum} expected LAT+1 negedges after drive
  string       tag_q[$];

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check_out(input logic [32:0] e, input string tag);
    logic ok;
    ok = 1'b1;
    checks++;
    if (out_valid !== e[32]) begin
      failures++;
      ok = 1'b0;
      $display("FAIL %s out_valid got=%0b exp=%0b", tag, out_valid, e[32]);
    end
    checks++;
    if (sum !== e[31:0]) begin
      failures++;
      ok = 1'b0;
      $display("FAIL %s sum got=%0d exp=%0d", tag, sum, e[31:0]);
    end
    if (tag == "sweep") begin
      if (ok) num_correct++;
      else    num_wrong++;
    end
  endtask

  task automatic check_rst(input string tag);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s out_valid got=%0b exp=0", tag, out_valid);
    end
    checks++;
    if (sum !== 32'h0) begin
      failures++;
      $display("FAIL %s sum got=%0d exp=0", tag, sum);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: check the output due now, then drive the next operand pair.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] e, input string tag);
    logic [32:0] exp_e;
    string       exp_t;
    @(negedge clk);
    if (exp_q.size() == LAT + 1) begin
      exp_e = exp_q.pop_front();
      exp_t = tag_q.pop_front();
      check_out(exp_e, exp_t);
    end
    in_valid = v;
    x        = a;
    y        = b;
    if (v) model_sum = e;
    exp_q.push_back({v, model_sum});
    tag_q.push_back(tag);
  endtask

  task automatic flush();
    repeat (LAT + 1) step(1'b0, 16'h0, 16'h0, 32'h0, "bubble");
  endtask

  // Reset one cycle after the last issue, between clock edges.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_rst("reset_async");
    exp_q.delete();
    tag_q.delete();
    model_sum = '0;
    @(posedge clk);
    #1;
    check_rst("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] e;

    checks      = 0;
    failures    = 0;
    num_correct = 0;
    num_wrong   = 0;
    model_sum   = '0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    x           = '0;
    y           = '0;

    vecs[0]  = '{16'h0000, 16'h0000, 32'h0000_0000};
    vecs[1]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2]  = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[3]  = '{16'h0001, 16'h0001, 32'h0000_0001};
    vecs[4]  = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
    vecs[5]  = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[6]  = '{16'hFFFF, 16'h8000, 32'h7FFF_8000};
    vecs[7]  = '{16'h8000, 16'hFFFF, 32'h7FFF_8000};
    vecs[8]  = '{16'hAAAA, 16'h5555, 32'd954408050};
    vecs[9]  = '{16'd1234, 16'd5678, 32'd7006652};
    vecs[10] = '{16'hFFFF, 16'hFFFE, 32'hFFFD_0002};
    vecs[11] = '{16'd1000, 16'd65000, 32'd65000000};

    // reset state, before any clock edge and across edges
    #2;
    check_rst("reset_pre_clk");
    repeat (2) @(posedge clk);
    #1;
    check_rst("reset_with_clk");
    @(negedge clk);
    rst_n = 1'b1;

    // corner-product table, streamed back to back
    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].x, vecs[i].y, vecs[i].exp, $sformatf("vec%0d", i));
    end
    flush();

    // sweep 0,1000,...,65000 squared against x*y
    for (int xi = 0; xi <= 65; xi++) begin
      for (int yi = 0; yi <= 65; yi++) begin
        a = 16'(xi * 1000);
        b = 16'(yi * 1000);
        e = {16'h0, a} * {16'h0, b};
        step(1'b1, a, b, e, "sweep");
      end
    end
    flush();
    $display("sweep num_correct=%0d num_wrong=%0d", num_correct, num_wrong);
    checks++;
    if (num_correct != 4356 || num_wrong != 0) begin
      failures++;
      $display("FAIL sweep_total correct=%0d wrong=%0d exp_correct=4356 exp_wrong=0",
               num_correct, num_wrong);
    end

    // streaming on consecutive cycles
    step(1'b1, 16'd1, 16'd1, 32'd1, "stream_1x1");
    step(1'b1, 16'd2, 16'd3, 32'd6, "stream_2x3");
    step(1'b1, 16'hFFFF, 16'd1, 32'd65535, "stream_ffffx1");
    flush();

    // bubble: valid 1,0,1 with sum holding through the gap
    step(1'b1, 16'd7, 16'd9, 32'd63, "bubble_a");
    step(1'b0, 16'd5, 16'd5, 32'd0, "bubble_gap");
    step(1'b1, 16'd11, 16'd13, 32'd143, "bubble_b");
    flush();

    // reset mid-operation: 300*400 must never emerge
    step(1'b1, 16'd300, 16'd400, 32'd120000, "rst_op");
    mid_reset();
    repeat (LAT + 5) step(1'b0, 16'h0, 16'h0, 32'h0, "post_rst_idle");

    // first valid after reset release is accepted normally
    step(1'b1, 16'd300, 16'd400, 32'd120000, "post_rst_op");
    step(1'b1, 16'h8000, 16'h0002, 32'h0001_0000, "post_rst_op2");
    flush();
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
